// File: rtl/aes_pkg.sv
// Shared AES constants, types and the key-schedule state encoding.
package aes_pkg;
  localparam int NR         = 10;
  localparam int AES_KEY_W  = 128;
  localparam int AES_WORD_W = 32;

  typedef logic [7:0]            aes_byte_t;
  typedef logic [AES_WORD_W-1:0] aes_word_t;

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } ke_state_e;

  // Indexed by the round being produced (1..10); other slots are never used.
  localparam aes_byte_t RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  // Entry for input 8'h00 sits in the top byte, so byte a lives at bit {~a, 3'b000}.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign s_o = SBOX_TBL[{~a_i, 3'b000} +: 8];
endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock, rk0..rk10.
// Optional KEY_STORE_EN adds an 11-entry round-key store with registered readback.
module aes_key_expand
  import aes_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 start,
  input  logic [AES_KEY_W-1:0] key_in,
  output logic [AES_KEY_W-1:0] round_key,
  output logic [3:0]           round_idx,
  output logic                 rk_valid,
  output logic                 busy,
  output logic                 done,
`ifdef KEY_STORE_EN
  input  logic [3:0]           rd_idx,
  output logic [AES_KEY_W-1:0] rd_key,
`endif
  output logic                 dbg_state_o
);
  // start is a request honoured only in IDLE; rk_valid marks every round_key/round_idx beat
  // and there is no backpressure, so the consumer must take each beat as it appears.
  localparam logic [3:0] LAST_IDX = 4'(NR);

  ke_state_e            state_q, state_d;
  logic [AES_KEY_W-1:0] key_q, key_d;
  logic [3:0]           idx_q, idx_d, idx_inc;
  logic                 done_q, done_d;

  aes_word_t            w3_rot, sub_w, t_w, nw0, nw1, nw2, nw3;
  logic [AES_KEY_W-1:0] next_key;

  assign w3_rot  = rot_word(key_q[31:0]);
  assign idx_inc = idx_q + 4'd1;

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .a_i (w3_rot[8*g +: 8]),
      .s_o (sub_w[8*g +: 8])
    );
  end

  assign t_w      = sub_w ^ {RCON[idx_inc], 24'h000000};
  assign nw0      = key_q[127:96] ^ t_w;
  assign nw1      = key_q[95:64]  ^ nw0;
  assign nw2      = key_q[63:32]  ^ nw1;
  assign nw3      = key_q[31:0]   ^ nw2;
  assign next_key = {nw0, nw1, nw2, nw3};

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EXPAND;
          key_d   = key_in;
          idx_d   = 4'd0;
        end
      end
      EXPAND: begin
        if (idx_q != LAST_IDX) begin
          key_d  = next_key;
          idx_d  = idx_inc;
          done_d = (idx_inc == LAST_IDX);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign round_key   = key_q;
  assign round_idx   = idx_q;
  assign rk_valid    = (state_q == EXPAND);
  assign busy        = (state_q == EXPAND);
  assign done        = done_q;
  assign dbg_state_o = state_q;

`ifdef KEY_STORE_EN
  logic [AES_KEY_W-1:0] store_q [NR+1];
  logic [AES_KEY_W-1:0] rd_key_q, rd_key_d;

  // Indices past the last round fall through to zero.
  always_comb begin
    rd_key_d = '0;
    for (int i = 0; i <= NR; i++) begin
      if (rd_idx == 4'(i)) rd_key_d = store_q[i];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i <= NR; i++) store_q[i] <= '0;
      rd_key_q <= '0;
    end else begin
      for (int i = 0; i <= NR; i++) begin
        if (state_q == EXPAND && idx_q == 4'(i)) store_q[i] <= key_q;
      end
      rd_key_q <= rd_key_d;
    end
  end

  assign rd_key = rd_key_q;
`endif
endmodule

// File: tb/tb_aes_key_expand.sv
// Randomised scoreboard bench for aes_key_expand against a FIPS-197 word-recurrence model.
// Build with +define+KEY_STORE_EN to include the round-key store readback checks.
module tb_aes_key_expand;
  localparam int W = 137;  // {gap_en, gap[2:0], done, idx[3:0], key[127:0]}

  localparam logic [127:0] K1      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KZ      = 128'h0;
  localparam logic [127:0] KZ_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] KZ_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         rk_valid, busy, done, dbg_state;
`ifdef KEY_STORE_EN
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
`endif

  aes_key_expand dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .start       (start),
    .key_in      (key_in),
    .round_key   (round_key),
    .round_idx   (round_idx),
    .rk_valid    (rk_valid),
    .busy        (busy),
    .done        (done),
`ifdef KEY_STORE_EN
    .rd_idx      (rd_idx),
    .rd_key      (rd_key),
`endif
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] item;
  int           checks = 0;
  int           errors = 0;
  int           idle_cnt = 0;
  logic [7:0]   sbox_m [256];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    return d[15-n -: 8];
  endfunction

  // S-box built from the GF(2^8) inverse plus the FIPS-197 affine map.
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] ab  = 8'(a);
      if (a != 0) begin
        for (int c = 1; c < 256; c++) begin
          if (gmul(ab, 8'(c)) == 8'h01) inv = 8'(c);
        end
      end
      sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] rk_ref(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic push_run(input logic [127:0] key, input bit gap_en, input bit use_kat,
                          input logic [127:0] kat1, input logic [127:0] kat10);
    logic [127:0] k;
    for (int r = 0; r <= 10; r++) begin
      k = rk_ref(key, r);
      if (use_kat && r == 1)  k = kat1;
      if (use_kat && r == 10) k = kat10;
      exp_q.push_back({(gap_en && r == 0), 3'd1, (r == 10), 4'(r), k});
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    if (RST_N === 1'b1) begin
      chk("busy_vs_valid", 128'(busy), 128'(rk_valid));
      if (rk_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid act=idx %0d key %h exp=no beat", round_idx, round_key);
        end else begin
          item = exp_q.pop_front();
          chk("round_key", round_key, item[127:0]);
          chk("round_idx", 128'(round_idx), 128'(item[131:128]));
          chk("done", 128'(done), 128'(item[132]));
          if (item[136]) chk("idle_gap", 128'(idle_cnt), 128'(item[135:133]));
        end
        idle_cnt = 0;
      end else begin
        chk("done_when_idle", 128'(done), 128'd0);
        idle_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Leaves the driver one ns after the edge that returns the DUT to IDLE.
  task automatic run_pulse(input logic [127:0] key, input bit gap_en, input bit use_kat,
                           input logic [127:0] kat1, input logic [127:0] kat10, input bit noise);
    start  = 1'b1;
    key_in = key;
    cyc();
    start  = 1'b0;
    key_in = rand128();
    push_run(key, gap_en, use_kat, kat1, kat10);
    for (int i = 0; i < 11; i++) begin
      start  = (noise && i < 10) ? 1'($urandom_range(0, 1)) : 1'b0;
      key_in = rand128();
      cyc();
    end
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    RST_N  = 1'b1;
    start  = 1'b0;
    key_in = '0;
`ifdef KEY_STORE_EN
    rd_idx = 4'd0;
`endif
    build_sbox();
    #3 RST_N = 1'b0;
    #9;
    chk("rst_round_key", round_key, 128'd0);
    chk("rst_round_idx", 128'(round_idx), 128'd0);
    chk("rst_rk_valid", 128'(rk_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_state", 128'(dbg_state), 128'd0);
`ifdef KEY_STORE_EN
    chk("rst_rd_key", rd_key, 128'd0);
`endif
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) cyc();

    // FIPS-197 key, single start pulse.
    run_pulse(K1, 1'b0, 1'b1, K1_RK1, K1_RK10, 1'b0);

`ifdef KEY_STORE_EN
    rd_idx = 4'd10;
    @(negedge CLK);
    chk("rd_latency_a", rd_key, K1);
    @(posedge CLK); #1;
    chk("rd_idx10", rd_key, K1_RK10);
    rd_idx = 4'd0;
    @(negedge CLK);
    chk("rd_latency_b", rd_key, K1_RK10);
    @(posedge CLK); #1;
    chk("rd_idx0", rd_key, K1);
    rd_idx = 4'd11;
    @(posedge CLK); #1;
    chk("rd_idx11", rd_key, 128'd0);
    rd_idx = 4'd5;
    @(posedge CLK); #1;
    chk("rd_idx5", rd_key, rk_ref(K1, 5));
    rd_idx = 4'd0;
`endif
    repeat (2) cyc();

    // All-zero key.
    run_pulse(KZ, 1'b0, 1'b1, KZ_RK1, KZ_RK10, 1'b0);
    repeat (2) cyc();

    // start held high with key_in churning; the second run takes key_in at the IDLE cycle.
    begin
      logic [127:0] k2;
      start  = 1'b1;
      key_in = K1;
      cyc();
      push_run(K1, 1'b0, 1'b1, K1_RK1, K1_RK10);
      for (int i = 0; i < 11; i++) begin
        key_in = rand128();
        cyc();
      end
      k2     = rand128();
      key_in = k2;
      push_run(k2, 1'b1, 1'b0, '0, '0);
      cyc();
      start  = 1'b0;
      key_in = rand128();
      repeat (11) cyc();
    end
    repeat (2) cyc();

    // Asynchronous reset in the middle of an expansion.
    begin
      logic [127:0] k3 = rand128();
      start  = 1'b1;
      key_in = k3;
      cyc();
      start  = 1'b0;
      push_run(k3, 1'b0, 1'b0, '0, '0);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (round_idx == 4'd5) begin
          found = 1'b1;
          break;
        end
        cyc();
      end
      chk("reach_idx5", 128'(found), 128'd1);
      @(negedge CLK);
      #1 RST_N = 1'b0;
      #1;
      chk("arst_round_key", round_key, 128'd0);
      chk("arst_round_idx", 128'(round_idx), 128'd0);
      chk("arst_rk_valid", 128'(rk_valid), 128'd0);
      chk("arst_busy", 128'(busy), 128'd0);
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
        @(negedge CLK);
        chk("arst_no_done", 128'(done), 128'd0);
      end
      RST_N = 1'b1;
      repeat (2) cyc();
      run_pulse(K1, 1'b0, 1'b1, K1_RK1, K1_RK10, 1'b0);
    end
    repeat (2) cyc();

    // Back-to-back: zero key starts at the first IDLE cycle after key 1.
    run_pulse(K1, 1'b0, 1'b1, K1_RK1, K1_RK10, 1'b0);
    run_pulse(KZ, 1'b1, 1'b1, KZ_RK1, KZ_RK10, 1'b0);

    // Random keys, random spacing, spurious start pulses while busy.
    for (int n = 0; n < 5; n++) begin
      repeat ($urandom_range(0, 3)) cyc();
      run_pulse(rand128(), 1'b0, 1'b0, '0, '0, 1'b1);
    end

    repeat (3) cyc();
    chk("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
